// File: rtl/mcpu_pkg.sv
// Shared constants for the multicycle MIPS control path.
//  - state_t       : 5-bit FSM state codes (0..15 used, 16..31 unreachable)
//  - opcode/funct  : instruction field encodings recognised by the decoder
//  - ALU_* codes   : ALU_operation encodings driven to the datapath
//  - select codes  : mux select encodings for the datapath
//  - alu_class_t   : how the ALU operation is chosen in a given state
//  - funct_to_alu  : R-type funct -> ALU operation (unknown funct -> add)
package mcpu_pkg;

  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_MEM_ADR = 5'd2,
    S_MEM_RD  = 5'd3,
    S_MEM_WB  = 5'd4,
    S_MEM_WR  = 5'd5,
    S_R_EX    = 5'd6,
    S_R_WB    = 5'd7,
    S_BEQ     = 5'd8,
    S_J       = 5'd9,
    S_I_EX    = 5'd10,
    S_I_WB    = 5'd11,
    S_LUI     = 5'd12,
    S_BNE     = 5'd13,
    S_JAL     = 5'd14,
    S_JR      = 5'd15
  } state_t;

  // Opcodes (Inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (Inst[5:0])
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU_operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Datapath select codes
  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;
  localparam logic [1:0] REGDST_RT    = 2'b00;
  localparam logic [1:0] REGDST_RD    = 2'b01;
  localparam logic [1:0] REGDST_RA    = 2'b10;
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_LUI      = 2'b10;
  localparam logic [1:0] M2R_PC       = 2'b11;
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef enum logic [1:0] {
    AC_ADD   = 2'd0,
    AC_SUB   = 2'd1,
    AC_FUNCT = 2'd2,
    AC_SLT   = 2'd3
  } alu_class_t;

  function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_XOR:  op = ALU_XOR;
      FN_NOR:  op = ALU_NOR;
      FN_SLT:  op = ALU_SLT;
      FN_SRL:  op = ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ALU operation decoder.
//  alu_class in  2  which rule selects the operation (add/sub/funct/slt)
//  funct     in  6  R-type funct field, used only for the funct class
//  alu_op    out 3  ALU_operation code for the datapath
module alu_op_decoder
  import mcpu_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (alu_class)
      AC_ADD:   alu_op = ALU_ADD;
      AC_SUB:   alu_op = ALU_SUB;
      AC_FUNCT: alu_op = funct_to_alu(funct);
      AC_SLT:   alu_op = ALU_SLT;
      default:  alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/m_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback from the opcode and funct
// held in the IR and drives every datapath select and write enable.
// Optional feature macro CTRL_MIO_WAIT_EN: when defined, IF/MEM_RD/MEM_WR
// stall while MIO_ready=0; when undefined MIO_ready is treated as always 1.
// Ports:
//  clk, reset (sync, active-high)     clock / reset
//  Inst[31:0], zero, MIO_ready         IR contents, ALU zero flag, memory ready
//  IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  1-bit controls
//  RegDst, MemtoReg, ALUSrcB, PCSource                               2-bit selects
//  ALU_operation[2:0], mem_w, CPU_MIO, illegal_op, state[4:0]
module m_control_fsm
  import mcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        MIO_ready,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic        mem_w,
  output logic        CPU_MIO,
  output logic        illegal_op,
  output logic [4:0]  state
);

  state_t     state_reg, state_next;
  alu_class_t alu_class;
  logic       ready;
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = Inst[31:26];
  assign funct  = Inst[5:0];

  // zero is consumed by the datapath branch logic (PCWriteCond/Branch),
  // and the middle IR bits are register/immediate fields.
`ifdef CTRL_MIO_WAIT_EN
  assign ready = MIO_ready;
  logic unused_bits;
  assign unused_bits = ^{zero, Inst[25:6]};
`else
  assign ready = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{zero, MIO_ready, Inst[25:6]};
`endif

  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = S_IF;
    IorD        = IORD_PC;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch      = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    mem_w       = 1'b0;
    CPU_MIO     = 1'b0;
    illegal_op  = 1'b0;
    alu_class   = AC_ADD;

    case (state_reg)
      S_IF: begin
        CPU_MIO    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        IRWrite    = ready;
        PCWrite    = ready;
        state_next = ready ? S_ID : S_IF;
      end
      S_ID: begin
        // Precompute the branch target into ALUOut while decoding.
        ALUSrcB = SRCB_SEXT_SH;
        case (opcode)
          OP_LW, OP_SW:    state_next = S_MEM_ADR;
          OP_RTYPE:        state_next = (funct == FN_JR) ? S_JR : S_R_EX;
          OP_BEQ:          state_next = S_BEQ;
          OP_BNE:          state_next = S_BNE;
          OP_J:            state_next = S_J;
          OP_JAL:          state_next = S_JAL;
          OP_ADDI, OP_SLTI: state_next = S_I_EX;
          OP_LUI:          state_next = S_LUI;
          default: begin
            illegal_op = 1'b1;
            state_next = S_IF;
          end
        endcase
      end
      S_MEM_ADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_SEXT;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        CPU_MIO    = 1'b1;
        IorD       = IORD_ALUOUT;
        state_next = ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        MemtoReg = M2R_MDR;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        CPU_MIO    = 1'b1;
        IorD       = IORD_ALUOUT;
        mem_w      = 1'b1;
        state_next = ready ? S_IF : S_MEM_WR;
      end
      S_R_EX: begin
        ALUSrcA    = SRCA_A;
        alu_class  = AC_FUNCT;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        RegDst   = REGDST_RD;
        RegWrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ALUSrcA     = SRCA_A;
        alu_class   = AC_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        Branch      = (state_reg == S_BEQ);
      end
      S_J: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      S_JAL: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = M2R_PC;
        RegWrite = 1'b1;
      end
      S_JR: begin
        PCSource = PCSRC_REG;
        PCWrite  = 1'b1;
      end
      S_I_EX: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_SEXT;
        alu_class  = (opcode == OP_SLTI) ? AC_SLT : AC_ADD;
        state_next = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_LUI: begin
        MemtoReg = M2R_LUI;
        RegWrite = 1'b1;
      end
      default: begin
        // Codes 16-31: outputs stay at their inactive defaults, return to IF.
        state_next = S_IF;
      end
    endcase

    // Reset gates every side effect immediately, not just on the next edge.
    if (reset) begin
      state_next  = S_IF;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      mem_w       = 1'b0;
      CPU_MIO     = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  alu_op_decoder u_alu_op_decoder (
    .alu_class (alu_class),
    .funct     (funct),
    .alu_op    (ALU_operation)
  );

endmodule

// File: tb/tb_m_control_fsm.sv
// Directed testbench for m_control_fsm: walks instruction classes through
// their state sequences and checks the decoded controls in each state.
module tb_m_control_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] Inst;
  logic        zero;
  logic        MIO_ready;
  logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic        mem_w, CPU_MIO, illegal_op;
  logic [4:0]  state;

  int total = 0;
  int bad   = 0;

  m_control_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .Inst          (Inst),
    .zero          (zero),
    .MIO_ready     (MIO_ready),
    .IorD          (IorD),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ALUSrcA       (ALUSrcA),
    .PCWrite       (PCWrite),
    .PCWriteCond   (PCWriteCond),
    .Branch        (Branch),
    .RegDst        (RegDst),
    .MemtoReg      (MemtoReg),
    .ALUSrcB       (ALUSrcB),
    .PCSource      (PCSource),
    .ALU_operation (ALU_operation),
    .mem_w         (mem_w),
    .CPU_MIO       (CPU_MIO),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {PCWrite, PCWriteCond, IRWrite, RegWrite, mem_w}
  function automatic logic [4:0] wen();
    return {PCWrite, PCWriteCond, IRWrite, RegWrite, mem_w};
  endfunction

  // Walk IF and ID for the current Inst, checking both states.
  task automatic fetch_decode(input string name);
    check_val({name, " IF state"}, 32'(state), 32'd0);
    check_val({name, " IF ctl {CPU_MIO,ALUSrcB,ALUop,IRW,PCW}"},
              32'({CPU_MIO, ALUSrcB, ALU_operation, IRWrite, PCWrite}),
              32'({1'b1, 2'b01, 3'b010, 1'b1, 1'b1}));
    tick();
    check_val({name, " ID state"}, 32'(state), 32'd1);
    check_val({name, " ID ctl {ALUSrcB,ALUop,wen}"},
              32'({ALUSrcB, ALU_operation, wen()}),
              32'({2'b11, 3'b010, 5'b00000}));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    Inst = 32'h0;
    zero = 1'b0;
    MIO_ready = 1'b1;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst state", 32'(state), 32'd0);
      check_val("rst wen/CPU_MIO", 32'({wen(), CPU_MIO}), 32'd0);
    end
    reset = 1'b0;
    #1;

    // add $9,$10,$11
    Inst = 32'h014B4820;
    #1;
    fetch_decode("add");
    check_val("add R_EX state", 32'(state), 32'd6);
    check_val("add R_EX {ALUSrcA,ALUSrcB,ALUop}", 32'({ALUSrcA, ALUSrcB, ALU_operation}),
              32'({1'b1, 2'b00, 3'b010}));
    tick();
    check_val("add R_WB state", 32'(state), 32'd7);
    check_val("add R_WB {RegDst,RegWrite}", 32'({RegDst, RegWrite}), 32'({2'b01, 1'b1}));
    tick();
    check_val("add back to IF", 32'(state), 32'd0);

    // R_EX ALU op for other functs: sub, srl, nor, unknown funct -> add
    begin
      logic [31:0] insts [4];
      logic [2:0]  ops   [4];
      insts[0] = 32'h014B4822; ops[0] = 3'b110;
      insts[1] = 32'h000B4842; ops[1] = 3'b101;
      insts[2] = 32'h014B4827; ops[2] = 3'b100;
      insts[3] = 32'h014B483F; ops[3] = 3'b010;
      for (int k = 0; k < 4; k++) begin
        Inst = insts[k];
        #1;
        tick(); tick();
        check_val($sformatf("R funct %02h ALUop", insts[k][5:0]), 32'(ALU_operation), 32'(ops[k]));
        tick(); tick();
      end
    end

    // lw $9,4($8)
    Inst = 32'h8D090004;
    #1;
    fetch_decode("lw");
    check_val("lw MEM_ADR state", 32'(state), 32'd2);
    check_val("lw MEM_ADR {ALUSrcA,ALUSrcB,ALUop}", 32'({ALUSrcA, ALUSrcB, ALU_operation}),
              32'({1'b1, 2'b10, 3'b010}));
    tick();
    check_val("lw MEM_RD state", 32'(state), 32'd3);
    check_val("lw MEM_RD {CPU_MIO,IorD,mem_w}", 32'({CPU_MIO, IorD, mem_w}), 32'({1'b1, 1'b1, 1'b0}));
    MIO_ready = 1'b0;
`ifdef CTRL_MIO_WAIT_EN
    tick();
    check_val("lw wait1 state", 32'(state), 32'd3);
    tick();
    check_val("lw wait2 state", 32'(state), 32'd3);
    MIO_ready = 1'b1;
    tick();
`else
    tick();
    MIO_ready = 1'b1;
`endif
    check_val("lw MEM_WB state", 32'(state), 32'd4);
    check_val("lw MEM_WB {MemtoReg,RegWrite}", 32'({MemtoReg, RegWrite}), 32'({2'b01, 1'b1}));
    tick();
    check_val("lw back to IF", 32'(state), 32'd0);

    // sw $9,4($8)
    Inst = 32'hAD090004;
    #1;
    fetch_decode("sw");
    tick();
    check_val("sw MEM_WR state", 32'(state), 32'd5);
    check_val("sw MEM_WR {CPU_MIO,IorD,mem_w,RegWrite}", 32'({CPU_MIO, IorD, mem_w, RegWrite}),
              32'({1'b1, 1'b1, 1'b1, 1'b0}));
    tick();
    check_val("sw back to IF", 32'(state), 32'd0);

    // beq $8,$9,3 with zero=1
    Inst = 32'h11090003;
    zero = 1'b1;
    #1;
    fetch_decode("beq");
    check_val("beq state", 32'(state), 32'd8);
    check_val("beq {PCWriteCond,Branch,PCSource,ALUop,ALUSrcA}",
              32'({PCWriteCond, Branch, PCSource, ALU_operation, ALUSrcA}),
              32'({1'b1, 1'b1, 2'b01, 3'b110, 1'b1}));
    tick();
    check_val("beq back to IF", 32'(state), 32'd0);
    zero = 1'b0;

    // bne
    Inst = 32'h15090003;
    #1;
    fetch_decode("bne");
    check_val("bne state", 32'(state), 32'd13);
    check_val("bne {PCWriteCond,Branch,PCSource}", 32'({PCWriteCond, Branch, PCSource}),
              32'({1'b1, 1'b0, 2'b01}));
    tick();

    // jal
    Inst = 32'h0C000010;
    #1;
    fetch_decode("jal");
    check_val("jal state", 32'(state), 32'd14);
    check_val("jal {PCWrite,PCSource,RegDst,MemtoReg,RegWrite}",
              32'({PCWrite, PCSource, RegDst, MemtoReg, RegWrite}),
              32'({1'b1, 2'b10, 2'b10, 2'b11, 1'b1}));
    tick();
    check_val("jal back to IF", 32'(state), 32'd0);

    // j
    Inst = 32'h08000010;
    #1;
    fetch_decode("j");
    check_val("j state/PCWrite/PCSource/RegWrite", 32'({state, PCWrite, PCSource, RegWrite}),
              32'({5'd9, 1'b1, 2'b10, 1'b0}));
    tick();

    // jr $31
    Inst = 32'h03E00008;
    #1;
    fetch_decode("jr");
    check_val("jr state/PCWrite/PCSource", 32'({state, PCWrite, PCSource}),
              32'({5'd15, 1'b1, 2'b11}));
    tick();

    // lui $1,0xABCD
    Inst = 32'h3C01ABCD;
    #1;
    fetch_decode("lui");
    check_val("lui state/MemtoReg/RegWrite", 32'({state, MemtoReg, RegWrite}),
              32'({5'd12, 2'b10, 1'b1}));
    tick();

    // addi / slti
    Inst = 32'h21290001;
    #1;
    fetch_decode("addi");
    check_val("addi I_EX", 32'({state, ALUSrcA, ALUSrcB, ALU_operation}),
              32'({5'd10, 1'b1, 2'b10, 3'b010}));
    tick();
    check_val("addi I_WB", 32'({state, RegWrite, RegDst, MemtoReg}),
              32'({5'd11, 1'b1, 2'b00, 2'b00}));
    tick();
    Inst = 32'h29290001;
    #1;
    fetch_decode("slti");
    check_val("slti I_EX ALUop", 32'({state, ALU_operation}), 32'({5'd10, 3'b111}));
    tick(); tick();

    // illegal opcode 0x3F
    Inst = 32'hFC000000;
    #1;
    check_val("illegal IF state", 32'(state), 32'd0);
    check_val("illegal_op low in IF", 32'(illegal_op), 32'd0);
    tick();
    check_val("illegal ID {state,illegal_op,wen}", 32'({state, illegal_op, wen()}),
              32'({5'd1, 1'b1, 5'b00000}));
    tick();
    check_val("illegal -> IF", 32'({state, illegal_op}), 32'({5'd0, 1'b0}));

    // Reset mid-instruction in R_WB: enables drop at once, IF next edge
    Inst = 32'h014B4820;
    #1;
    tick(); tick(); tick();
    check_val("midrst pre R_WB RegWrite", 32'({state, RegWrite}), 32'({5'd7, 1'b1}));
    reset = 1'b1;
    #1;
    check_val("midrst RegWrite gated", 32'(wen()), 32'd0);
    tick();
    check_val("midrst state IF", 32'(state), 32'd0);
    check_val("midrst IF gated {wen,CPU_MIO}", 32'({wen(), CPU_MIO}), 32'd0);
    reset = 1'b0;
    #1;
    check_val("post-rst IF IRWrite", 32'(IRWrite), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
